// File: rtl/codec_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : codec_cfg_sequencer_if
//  Description : Control-bus bundle between the codec configuration
//                sequencer, the I2C write master and the volume controls.
//  Revision    : 1.0 - initial release
// ============================================================================
interface codec_cfg_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int VOL_W  = 8
);
    logic              i2c_ready;
    logic [ADDR_W-1:0] i2c_address;
    logic [DATA_W-1:0] i2c_data;
    logic              i2c_enable;
    logic              vol_up;
    logic              vol_down;
    logic [VOL_W-1:0]  volume;
    logic              init_done;
    logic              error;

    // Sequencer side: drives the write request and status
    modport master (
        input  i2c_ready, vol_up, vol_down,
        output i2c_address, i2c_data, i2c_enable, volume, init_done, error
    );

    // I2C master / control side
    modport slave (
        output i2c_ready, vol_up, vol_down,
        input  i2c_address, i2c_data, i2c_enable, volume, init_done, error
    );
endinterface
`default_nettype wire

// File: rtl/codec_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : codec_cfg_sequencer
//  Description : Writes a table of codec register settings after reset, then
//                issues volume-register writes whenever the volume changes.
//                One write per I2C master handshake, with timeout detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module codec_cfg_sequencer #(
    parameter int                                    ADDR_W     = 16,
    parameter int                                    DATA_W     = 16,
    parameter int                                    NUM_INIT   = 10,
    parameter logic [NUM_INIT*(ADDR_W+DATA_W)-1:0]   INIT_TABLE = {
        16'h0009, 16'h0001,   // entry 9: activate
        16'h0006, 16'h0000,   // entry 8: power up all
        16'h0008, 16'h0000,   // entry 7: sample rate
        16'h0007, 16'h0002,   // entry 6: digital interface format
        16'h0005, 16'h0000,   // entry 5: digital path
        16'h0004, 16'h0012,   // entry 4: analogue path
        16'h0002, 16'h0079,   // entry 3: headphone volume
        16'h0000, 16'h0017,   // entry 2: line-in volume
        16'h0006, 16'h0010,   // entry 1: power down outputs during setup
        16'h000F, 16'h0000    // entry 0: soft reset
    },
    parameter logic [ADDR_W-1:0]                     VOL_ADDR   = 16'h0022,
    parameter int                                    VOL_W      = 8,
    parameter logic [VOL_W-1:0]                      VOL_INIT   = 8'd90,
    parameter logic [VOL_W-1:0]                      VOL_MIN    = 8'd0,
    parameter logic [VOL_W-1:0]                      VOL_MAX    = 8'd255,
    parameter logic [VOL_W-1:0]                      VOL_STEP   = 8'd4,
    parameter int                                    TIMEOUT    = 1024
) (
    input wire                        clk50,
    input wire                        reset,
    codec_cfg_sequencer_if.master     bus
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int IDX_W   = $clog2(NUM_INIT + 1);
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] C_IDX_END  = IDX_W'(NUM_INIT);

    typedef enum logic [2:0] {
        S_ISSUE  = 3'd0,
        S_BUSY   = 3'd1,
        S_FINISH = 3'd2,
        S_NEXT   = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt, w_idx_inc;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic                r_enable, w_enable_nxt;
    logic                r_init_done, w_init_done_nxt;
    logic                r_error, w_error_nxt;
    logic                w_pending_clr;
    logic [ENTRY_W-1:0]  w_entry;

    logic [VOL_W-1:0]    r_vol, w_vol_nxt;
    logic                r_vol_pending, w_vol_changed;
    logic [VOL_W:0]      w_vol_sum, w_vol_dif;

    // Extra bit keeps step arithmetic free of wrap-around
    assign w_vol_sum = {1'b0, r_vol} + {1'b0, VOL_STEP};
    assign w_vol_dif = {1'b0, r_vol} - {1'b0, VOL_STEP};
    assign w_idx_inc = r_idx + IDX_W'(1);

    // Saturating volume step; a press that cannot move the value is not a change
    always_comb begin
        w_vol_nxt = r_vol;
        if (bus.vol_up && !bus.vol_down) begin
            w_vol_nxt = (w_vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : w_vol_sum[VOL_W-1:0];
        end else if (bus.vol_down && !bus.vol_up) begin
            w_vol_nxt = (w_vol_dif[VOL_W] || (w_vol_dif < {1'b0, VOL_MIN}))
                        ? VOL_MIN : w_vol_dif[VOL_W-1:0];
        end
        w_vol_changed = (w_vol_nxt != r_vol);
    end

    // Select the current table entry with constant part-selects only
    always_comb begin
        w_entry = '0;
        for (int i = 0; i < NUM_INIT; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_entry = INIT_TABLE[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

    // Next-state and next-output decode for the write handshake
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_enable_nxt    = 1'b0;
        w_init_done_nxt = r_init_done;
        w_error_nxt     = r_error;
        w_pending_clr   = 1'b0;
        case (r_state)
            S_ISSUE: begin
                if (bus.i2c_ready) begin
                    w_enable_nxt = 1'b1;
                    w_state_nxt  = S_BUSY;
                    if (r_init_done) begin
                        w_addr_nxt = VOL_ADDR;
                        w_data_nxt = DATA_W'({r_vol, r_vol});
                    end else begin
                        w_addr_nxt = w_entry[ENTRY_W-1:DATA_W];
                        w_data_nxt = w_entry[DATA_W-1:0];
                    end
                end
            end
            S_BUSY: begin
                if (!bus.i2c_ready) begin
                    w_state_nxt = S_FINISH;
                end else if (r_cnt == C_CNT_LAST) begin
                    // Master never picked the write up; drop it and move on
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_NEXT;
                end
            end
            S_FINISH: begin
                if (bus.i2c_ready) begin
                    w_state_nxt = S_NEXT;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_error_nxt = 1'b1;
                end
            end
            S_NEXT: begin
                if (!r_init_done) begin
                    w_idx_nxt = w_idx_inc;
                    if (w_idx_inc == C_IDX_END) begin
                        w_init_done_nxt = 1'b1;
                        w_state_nxt     = S_RUN;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_vol_pending) begin
                    w_pending_clr = 1'b1;
                    w_state_nxt   = S_ISSUE;
                end
            end
            default: begin
                w_state_nxt = S_ISSUE;
            end
        endcase
    end

    // State, handshake outputs and timeout counter (cleared on each state entry)
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state     <= S_ISSUE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_enable    <= 1'b0;
            r_init_done <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_enable    <= w_enable_nxt;
            r_init_done <= w_init_done_nxt;
            r_error     <= w_error_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Volume register and pending flag; a fresh change beats the clear
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_vol         <= VOL_INIT;
            r_vol_pending <= 1'b1;
        end else begin
            r_vol <= w_vol_nxt;
            if (w_vol_changed) begin
                r_vol_pending <= 1'b1;
            end else if (w_pending_clr) begin
                r_vol_pending <= 1'b0;
            end
        end
    end

    assign bus.i2c_address = r_addr;
    assign bus.i2c_data    = r_data;
    assign bus.i2c_enable  = r_enable;
    assign bus.volume      = r_vol;
    assign bus.init_done   = r_init_done;
    assign bus.error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_codec_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_codec_cfg_sequencer
//  Description : Self-checking bench for codec_cfg_sequencer with a simple
//                I2C master model and a saturating volume reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_cfg_sequencer;

    localparam int NUM_INIT = 10;
    localparam int STEP     = 4;

    function automatic logic [15:0] tb_addr(input int i);
        return 16'h0100 + 16'(i * 3);
    endfunction

    function automatic logic [15:0] tb_data(input int i);
        return 16'hA000 ^ 16'(i * 16'h1111);
    endfunction

    function automatic logic [NUM_INIT*32-1:0] make_table();
        logic [NUM_INIT*32-1:0] t;
        t = '0;
        for (int i = 0; i < NUM_INIT; i++) t[i*32 +: 32] = {tb_addr(i), tb_data(i)};
        return t;
    endfunction

    localparam logic [NUM_INIT*32-1:0] TB_TABLE = make_table();

    logic clk50;
    logic reset;
    codec_cfg_sequencer_if #(.ADDR_W(16), .DATA_W(16), .VOL_W(8)) bus ();

    codec_cfg_sequencer #(
        .NUM_INIT   (NUM_INIT),
        .INIT_TABLE (TB_TABLE)
    ) dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mode     = 1;     // 0: 3-cycle busy, 1: ready held low, 2: never busy
    int          model_vol;
    bit          model_changed;
    logic [31:0] log_q[$];

    // I2C master model: records each write request and plays the ready handshake
    initial begin
        int busy_cnt;
        int since_en;
        busy_cnt = 0;
        since_en = 100;
        bus.i2c_ready = 1'b0;
        forever begin
            @(negedge clk50);
            since_en++;
            if (bus.i2c_enable === 1'b1) begin
                n_checks++;
                if (since_en < 4) $display("FAIL enable_spacing: got %0d cycles required >=4", since_en);
                else n_pass++;
                since_en = 0;
                log_q.push_back({bus.i2c_address, bus.i2c_data});
                if (mode == 0) busy_cnt = 3;
            end
            if (mode == 1) bus.i2c_ready = 1'b0;
            else if (busy_cnt > 0) begin
                bus.i2c_ready = 1'b0;
                busy_cnt--;
            end else bus.i2c_ready = 1'b1;
        end
    end

    task automatic pulse(input logic up, input logic dn);
        int old;
        @(negedge clk50);
        bus.vol_up   = up;
        bus.vol_down = dn;
        old = model_vol;
        if (up && !dn) model_vol = (model_vol + STEP > 255) ? 255 : model_vol + STEP;
        else if (dn && !up) model_vol = (model_vol - STEP < 0) ? 0 : model_vol - STEP;
        if (model_vol != old) model_changed = 1'b1;
        @(negedge clk50);
        bus.vol_up   = 1'b0;
        bus.vol_down = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk50);
        reset = 1'b1;
        repeat (2) @(negedge clk50);
        reset = 1'b0;
        log_q.delete();
        model_vol = 90;
    endtask

    task automatic wait_init_done();
        int n;
        n = 0;
        while (bus.init_done !== 1'b1 && n < 400) begin
            @(negedge clk50);
            n++;
        end
        n_checks++;
        if (bus.init_done !== 1'b1) $display("FAIL init_timeout: init_done=%b required 1", bus.init_done);
        else n_pass++;
        repeat (30) @(negedge clk50);
    endtask

    task automatic test_reset();
        mode = 1;
        @(negedge clk50);
        reset = 1'b1;
        repeat (3) @(negedge clk50);
        n_checks++;
        if ({bus.i2c_enable, bus.i2c_address, bus.i2c_data} !== 33'd0)
            $display("FAIL reset_bus: got en=%b a=%h d=%h required 0/0000/0000",
                     bus.i2c_enable, bus.i2c_address, bus.i2c_data);
        else n_pass++;
        n_checks++;
        if ({bus.init_done, bus.error} !== 2'b00)
            $display("FAIL reset_flags: got init_done=%b error=%b required 0 0", bus.init_done, bus.error);
        else n_pass++;
        n_checks++;
        if (bus.volume !== 8'd90) $display("FAIL reset_volume: got %0d required 90", bus.volume);
        else n_pass++;
        reset = 1'b0;
        log_q.delete();
        model_vol = 90;
        repeat (500) @(negedge clk50);
        n_checks++;
        if (log_q.size() != 0) $display("FAIL ready_low_no_enable: got %0d enables required 0", log_q.size());
        else n_pass++;
        mode = 0;
    endtask

    task automatic test_init();
        wait_init_done();
        n_checks++;
        if (log_q.size() != NUM_INIT + 1) $display("FAIL init_count: got %0d required %0d", log_q.size(), NUM_INIT + 1);
        else n_pass++;
        for (int i = 0; i < NUM_INIT && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i] !== {tb_addr(i), tb_data(i)})
                $display("FAIL init_entry%0d: got %h required %h", i, log_q[i], {tb_addr(i), tb_data(i)});
            else n_pass++;
        end
        n_checks++;
        if (log_q.size() < NUM_INIT + 1 || log_q[NUM_INIT] !== 32'h0022_5A5A)
            $display("FAIL init_vol_write: got %h required 00225a5a",
                     (log_q.size() > NUM_INIT) ? log_q[NUM_INIT] : 32'hx);
        else n_pass++;
        n_checks++;
        if (bus.error !== 1'b0) $display("FAIL init_error: got %b required 0", bus.error);
        else n_pass++;
    endtask

    task automatic test_vol_up();
        log_q.delete();
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            repeat ($urandom_range(0, 5)) @(negedge clk50);
        end
        repeat (60) @(negedge clk50);
        n_checks++;
        if (bus.volume !== 8'(model_vol) || model_vol != 102)
            $display("FAIL vol_up_value: got %0d required 102", bus.volume);
        else n_pass++;
        n_checks++;
        if (log_q.size() == 0 || log_q[$] !== 32'h0022_6666)
            $display("FAIL vol_up_write: got %h required 00226666", (log_q.size() != 0) ? log_q[$] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_random_vol();
        log_q.delete();
        model_changed = 1'b0;
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            pulse(kind[0], kind[1]);
            n_checks++;
            if (bus.volume !== 8'(model_vol))
                $display("FAIL rand_vol_%0d: got %0d required %0d", i, bus.volume, model_vol);
            else n_pass++;
            repeat ($urandom_range(0, 3)) @(negedge clk50);
        end
        repeat (60) @(negedge clk50);
        n_checks++;
        if (model_changed && (log_q.size() == 0 || log_q[$] !== {16'h0022, 8'(model_vol), 8'(model_vol)}))
            $display("FAIL rand_last_write: got %h required %h",
                     (log_q.size() != 0) ? log_q[$] : 32'hx, {16'h0022, 8'(model_vol), 8'(model_vol)});
        else if (!model_changed && log_q.size() != 0)
            $display("FAIL rand_no_write: got %0d writes required 0", log_q.size());
        else n_pass++;
    endtask

    task automatic test_saturate_high();
        for (int i = 0; i < 70; i++) pulse(1'b1, 1'b0);
        repeat (60) @(negedge clk50);
        n_checks++;
        if (bus.volume !== 8'd255 || model_vol != 255) $display("FAIL sat_high: got %0d required 255", bus.volume);
        else n_pass++;
        n_checks++;
        if (log_q.size() == 0 || log_q[$] !== 32'h0022_FFFF)
            $display("FAIL sat_high_write: got %h required 0022ffff", (log_q.size() != 0) ? log_q[$] : 32'hx);
        else n_pass++;
        log_q.delete();
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        repeat (30) @(negedge clk50);
        n_checks++;
        if (log_q.size() != 0 || bus.volume !== 8'd255)
            $display("FAIL sat_high_quiet: got %0d writes vol=%0d required 0 writes vol=255", log_q.size(), bus.volume);
        else n_pass++;
    endtask

    task automatic test_saturate_low();
        apply_reset();
        wait_init_done();
        log_q.delete();
        for (int i = 0; i < 30; i++) pulse(1'b0, 1'b1);
        repeat (60) @(negedge clk50);
        n_checks++;
        if (bus.volume !== 8'd0 || model_vol != 0) $display("FAIL sat_low: got %0d required 0", bus.volume);
        else n_pass++;
        n_checks++;
        if (log_q.size() == 0 || log_q[$] !== 32'h0022_0000)
            $display("FAIL sat_low_write: got %h required 00220000", (log_q.size() != 0) ? log_q[$] : 32'hx);
        else n_pass++;
        log_q.delete();
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
        repeat (30) @(negedge clk50);
        n_checks++;
        if (log_q.size() != 0 || bus.volume !== 8'd0)
            $display("FAIL sat_low_quiet: got %0d writes vol=%0d required 0 writes vol=0", log_q.size(), bus.volume);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        mode = 2;
        apply_reset();
        n = 0;
        while (bus.i2c_enable !== 1'b1 && n < 50) begin
            @(negedge clk50);
            n++;
        end
        n = 0;
        while (bus.error !== 1'b1 && n < 1200) begin
            @(negedge clk50);
            n++;
            if (n == 1010) mode = 0;
        end
        mode = 0;
        n_checks++;
        if (bus.error !== 1'b1 || n < 1022 || n > 1026)
            $display("FAIL timeout_error: got error=%b after %0d cycles required 1 after ~1024", bus.error, n);
        else n_pass++;
        wait_init_done();
        n_checks++;
        if (log_q.size() < 2 || log_q[0] !== {tb_addr(0), tb_data(0)} || log_q[1] !== {tb_addr(1), tb_data(1)})
            $display("FAIL timeout_advance: got %0d writes second=%h required second=%h",
                     log_q.size(), (log_q.size() > 1) ? log_q[1] : 32'hx, {tb_addr(1), tb_data(1)});
        else n_pass++;
        n_checks++;
        if (log_q.size() != NUM_INIT + 1 || bus.error !== 1'b1)
            $display("FAIL timeout_sticky: got %0d writes error=%b required %0d writes error=1",
                     log_q.size(), bus.error, NUM_INIT + 1);
        else n_pass++;
    endtask

    task automatic test_reset_midtransfer();
        int n;
        apply_reset();
        n = 0;
        while (!(bus.i2c_enable === 1'b1 && bus.i2c_address === tb_addr(5)) && n < 300) begin
            @(negedge clk50);
            n++;
        end
        n_checks++;
        if (n >= 300) $display("FAIL mid_reach_entry5: got no entry-5 enable required one");
        else n_pass++;
        reset = 1'b1;
        @(negedge clk50);
        n_checks++;
        if ({bus.i2c_enable, bus.i2c_address, bus.i2c_data, bus.init_done, bus.error} !== 35'd0 ||
            bus.volume !== 8'd90)
            $display("FAIL mid_reset_values: got en=%b a=%h d=%h done=%b err=%b vol=%0d required all 0, vol 90",
                     bus.i2c_enable, bus.i2c_address, bus.i2c_data, bus.init_done, bus.error, bus.volume);
        else n_pass++;
        reset = 1'b0;
        log_q.delete();
        model_vol = 90;
        wait_init_done();
        n_checks++;
        if (log_q.size() != NUM_INIT + 1 || log_q[0] !== {tb_addr(0), tb_data(0)})
            $display("FAIL mid_restart: got %0d writes first=%h required %0d first=%h", log_q.size(),
                     (log_q.size() != 0) ? log_q[0] : 32'hx, NUM_INIT + 1, {tb_addr(0), tb_data(0)});
        else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        bus.vol_up   = 1'b0;
        bus.vol_down = 1'b0;
        model_vol    = 90;
        test_reset();
        test_init();
        test_vol_up();
        test_random_vol();
        test_saturate_high();
        test_saturate_low();
        test_timeout();
        test_reset_midtransfer();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
